// File: rtl/edge_pkg.sv
// Shared types and kernel arithmetic for the 3x3 streaming edge engine.
package edge_pkg;

  typedef enum logic [1:0] {
    LAPLACE8 = 2'd0,
    SOBEL_X  = 2'd1,
    SOBEL_Y  = 2'd2,
    PASS     = 2'd3
  } mode_e;

  // Signed result must hold +/-8*(2^pix_w-1).
  function automatic int out_w(input int pix_w);
    return pix_w + 4;
  endfunction

  // Taps row-major, p1 top-left; inputs are already zero-extended.
  function automatic int kernel(
    input mode_e m,
    input int p1, input int p2, input int p3,
    input int p4, input int p5, input int p6,
    input int p7, input int p8, input int p9
  );
    int r;
    r = 0;
    case (m)
      LAPLACE8: r = 8 * p5 - (p1 + p2 + p3 + p4 + p6 + p7 + p8 + p9);
      SOBEL_X:  r = (p3 + 2 * p6 + p9) - (p1 + 2 * p4 + p7);
      SOBEL_Y:  r = (p7 + 2 * p8 + p9) - (p1 + 2 * p2 + p3);
      PASS:     r = p5;
      default:  r = 0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/edge_stream_3x3_line_buffer.sv
// Read-first line store: combinational read of old data,
// write of new data at the same address on the clock edge.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/edge_stream_3x3.sv
// Streaming 3x3 convolution: raster pixels in, signed result
// plus threshold flag out, one pixel per clock at full rate.
module edge_stream_3x3
  import edge_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int OUT_W = out_w(PIX_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       mode,
  input  logic [OUT_W-2:0] thresh,
  output logic [OUT_W-1:0] m_data,
  output logic             m_edge,
  output logic             m_eol,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);

  logic          accept;
  logic          produce;
  logic [CW-1:0] col, cur_col;
  logic [1:0]    row, cur_row;
  mode_e         mode_r;

  logic [PIX_W-1:0] l1_rd, l2_rd;
  logic [PIX_W-1:0] w0_t, w0_m, w0_b;
  logic [PIX_W-1:0] w1_t, w1_m, w1_b;

  int k;
  int mag;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // Start-of-frame overrides the counters for the current beat.
  assign cur_col = s_sof ? '0 : col;
  assign cur_row = s_sof ? 2'd0 : row;
  assign produce = (cur_row == 2'd2) && (cur_col >= CW'(2));

  line_buffer #(
    .DEPTH (IMG_W),
    .W     (2 * PIX_W)
  ) u_lines (
    .clk     (clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data ({l1_rd, s_data}),
    .rd_data ({l2_rd, l1_rd})
  );

  always_comb begin
    k = kernel(mode_r,
      int'(w0_t), int'(w1_t), int'(l2_rd),
      int'(w0_m), int'(w1_m), int'(l1_rd),
      int'(w0_b), int'(w1_b), int'(s_data));
    mag = (k < 0) ? -k : k;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= 2'd0;
      mode_r <= LAPLACE8;
      w0_t   <= '0;
      w0_m   <= '0;
      w0_b   <= '0;
      w1_t   <= '0;
      w1_m   <= '0;
      w1_b   <= '0;
    end else if (accept) begin
      if (s_sof) mode_r <= mode_e'(mode);
      if (cur_col == LAST) begin
        col <= '0;
        row <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
      w0_t <= w1_t;
      w0_m <= w1_m;
      w0_b <= w1_b;
      w1_t <= l2_rd;
      w1_m <= l1_rd;
      w1_b <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_edge  <= 1'b0;
      m_eol   <= 1'b0;
    end else if (accept && produce) begin
      m_valid <= 1'b1;
      m_data  <= OUT_W'(k);
      m_edge  <= mag >= int'(thresh);
      m_eol   <= cur_col == LAST;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
